// File: rtl/bram_pixel_unpacker.sv
// Reads a run of 32-bit words from the BRAM B port and streams them out as
// 8-bit pixels, low byte first, on a valid/ready interface with credit-based issue.
module bram_pixel_unpacker #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clkb,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [31:0]       doutb,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + RD_LAT + 2);
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    issue_left_q, issue_left_d;
    logic [LEN_W-1:0]    pop_left_q, pop_left_d;
    logic [RD_LAT-1:0]   pipe_q, pipe_d;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [31:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [1:0]          byte_q, byte_d;
    logic                busy_q, busy_d, done_q, done_d, enb_q, enb_d;
    logic [ADDR_W-1:0]   addrb_q, addrb_d;
    logic [7:0]          pix_data_q, pix_data_d;
    logic                pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;

    logic                wr, xfer, pop, credit_ok;
    logic [31:0]         head;
    logic [CRD_W-1:0]    inflight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: FIFO bookkeeping, credit check, FSM and output registers
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        enb_d        = 1'b0;
        addrb_d      = addrb_q;
        mem_d        = mem_q;

        wr   = pipe_q[RD_LAT-1];
        xfer = pix_valid_q & pix_ready;
        pop  = xfer & (byte_q == 2'd3);

        pipe_d[0] = enb_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (wr) begin
            mem_d[wr_ptr_q] = doutb;
        end
        wr_ptr_d   = wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + CNT_W'(wr) - CNT_W'(pop);
        byte_d     = byte_q + 2'(xfer);
        pop_left_d = pop_left_q - LEN_W'(pop);

        // A word written this edge into an otherwise-empty FIFO becomes the head
        head = (wr && (count_q == CNT_W'(pop))) ? doutb : mem_q[rd_ptr_d];

        // Reads still outstanding after this edge plus post-edge occupancy
        inflight = CRD_W'(enb_q) + CRD_W'(count_d);
        for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
            inflight = inflight + CRD_W'(pipe_q[i]);
        end
        credit_ok = (inflight < CRD_W'(FIFO_DEPTH));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pop_left_d = num_words;
                    if (num_words == '0) begin
                        state_d = S_DONE;
                    end else begin
                        enb_d        = 1'b1;
                        addrb_d      = base_addr;
                        addr_d       = base_addr + ADDR_W'(1);
                        issue_left_d = num_words - LEN_W'(1);
                        state_d      = (num_words == LEN_W'(1)) ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    enb_d        = 1'b1;
                    addrb_d      = addr_q;
                    addr_d       = addr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - LEN_W'(1);
                    if (issue_left_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop_left_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        pix_valid_d = (count_d != '0);
        pix_data_d  = head[{byte_d, 3'b000} +: 8];
        pix_last_d  = pix_valid_d && (byte_d == 2'd3) && (pop_left_d == LEN_W'(1));
    end

    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            pipe_q       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            byte_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            enb_q        <= 1'b0;
            addrb_q      <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            pipe_q       <= pipe_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            byte_q       <= byte_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            enb_q        <= enb_d;
            addrb_q      <= addrb_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_last_q   <= pix_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign enb       = enb_q;
    assign addrb     = addrb_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;

endmodule

// File: doc/bram_pixel_unpacker.md
Name: bram_pixel_unpacker

Overview:
- Read-side consumer of the bram18 line buffer, which is written 8 bits wide (2048 x 8) and read 32 bits wide (512 x 32).
- On a start command it fetches a run of 32-bit words through the B port (enb/addrb/doutb).
- It unpacks each word into four 8-bit pixels and presents them on a valid/ready stream to the next image-processing stage.
- It absorbs BRAM read latency and downstream backpressure without losing or duplicating pixels.

Parameters:
- ADDR_W, 9, BRAM B-port address width (512 words).
- RD_LAT, 1, BRAM read latency in clocks from the enb/addrb edge to valid doutb (legal values 1 and 2).
- FIFO_DEPTH, 2, internal word buffer depth; must be at least RD_LAT+1.

Ports:
- clkb  in  1  single clock; also drives the BRAM B port.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- base_addr  in  ADDR_W  first word address; sampled with start.
- num_words  in  ADDR_W+1  number of words to read, 0..512; sampled with start.
- busy  out  1  high from the edge after an accepted start until the edge on which done pulses.
- done  out  1  one-cycle pulse after the last pixel handshake, or after the start of a zero-length job.
- enb  out  1  BRAM B-port read enable.
- addrb  out  ADDR_W  BRAM B-port word address.
- doutb  in  32  BRAM read data.
- pix_data  out  8  pixel.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  downstream accepts; a transfer occurs when valid and ready are both high at a clkb edge.
- pix_last  out  1  high together with the final pixel of the job.

Behaviour:
- Reset (async assert, sync release):
  - busy, done, enb, pix_valid and pix_last = 0.
  - addrb, pix_data = 0.
  - FIFO, byte index and counters cleared.
  - Asserting reset mid-job aborts the job. No done pulse is generated, and the next start after release behaves normally.
- FSM states:
  - IDLE: start=1 latches base_addr and num_words, then goes to RUN. If num_words=0, it goes instead to DONE (busy stays 0, done pulses the next cycle).
  - RUN: issues reads. Moves to DRAIN when all words are issued.
  - DRAIN: waits until the FIFO is empty and the final pixel has transferred, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Read issue:
  - enb=1 only in cycles where a read is issued, with addrb = current address.
  - A read issues only when (words in flight + FIFO occupancy) < FIFO_DEPTH. This credit rule guarantees no FIFO overflow.
  - The address increments by 1 per issue and wraps from 2^ADDR_W-1 to 0.
- Capture: doutb is written into the FIFO exactly RD_LAT edges after the issuing edge. This uses a RD_LAT-deep shift register of issue flags.
- Unpack order:
  - The head word yields pixels doutb[7:0], [15:8], [23:16], [31:24] in that order.
  - A 2-bit byte index advances on each transfer. The word pops on the transfer of byte 3.
- Output register:
  - pix_valid = FIFO not empty.
  - pix_data/pix_valid hold stable while pix_valid=1 and pix_ready=0.
- pix_last = 1 only on byte 3 of word num_words-1.
- Latency: with start sampled at edge E0:
  - First enb=1 follows E0.
  - First pix_valid=1 follows edge E0+1+RD_LAT.
- Throughput: with pix_ready held at 1, exactly one pixel transfers per cycle from the first pixel to the last, with no bubbles.
- Boundary conditions:
  - num_words=512 reads every address once, wrapping as needed.
  - Backpressure of any length loses nothing.
  - start while busy has no effect.
  - pix_ready toggling every cycle yields correct order.
  - done and a new start may be accepted in consecutive cycles: a start coincident with done is ignored, and start is accepted from IDLE.

Test Plan:
- BRAM words 0..3 = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; start base=0, num=4, ready=1 -> pix_data 0x00..0x0F on 16 consecutive cycles; pix_last only on 0x0F; done 1 cycle after; first valid after E0+2 (RD_LAT=1).
- Same job with pix_ready=0 for cycles 3..12, then 1 -> stream stalls with pix_data held; no pixel lost or duplicated; FIFO never exceeds 2 words; enb stops while credits are exhausted.
- base=510, num=4 -> addrb sequence 510, 511, 0, 1; 16 pixels in that word order.
- num_words=0 -> enb never asserted, pix_valid stays 0, done pulses on the cycle after start.
- rst_n low for 1 cycle mid-job (after 5 pixels) -> all outputs 0 immediately; no done; a fresh start base=0 num=1 then yields 0x00..0x03 with pix_last on 0x03.
- Random pix_ready (50%), num=512 with RD_LAT=2 -> scoreboard matches all 2048 bytes in order; exactly one done pulse.
